// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parameterised FIFO with level and almost flags
//
// Purpose: stores up to DEPTH words of DATA_W bits in strict arrival order. Pointers
// wrap at DEPTH-1 for any DEPTH (power of two not needed). The head word is shown on
// data_out one edge after it is pushed; there is no bypass path.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   flush         in   synchronous clear of pointers and level
//   data_in       in   write data (DATA_W)
//   data_in_vld   in   write request
//   data_in_rdy   out  space available and not in reset/flush
//   data_out      out  head-of-queue word, zero when empty
//   data_out_vld  out  FIFO holds at least one word
//   data_out_rdy  in   consumer takes data_out
//   level         out  number of stored words (LVL_W)
//   almost_full   out  level >= AF_LEVEL
//   almost_empty  out  level <= AE_LEVEL
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_vld,
    output logic              data_in_rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_vld,
    input  logic              data_out_rdy,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF    = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] LVL_AE    = LVL_W'(AE_LEVEL);

    // Storage is deliberately left out of reset; only control state is cleared.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic wr_en;
    logic rd_en;

    // rst is folded in so that ready rises combinationally on reset release.
    assign data_in_rdy  = rst && !flush && (level_q < LVL_FULL);
    assign data_out_vld = (level_q != '0);
    assign data_out     = data_out_vld ? mem[rd_ptr_q] : '0;
    assign level        = level_q;
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);

    // wr_en already excludes flush through data_in_rdy.
    assign wr_en = data_in_vld && data_in_rdy;
    assign rd_en = data_out_vld && data_out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Explicit wrap compare keeps non-power-of-two depths inside 0..DEPTH-1.
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - randomized self-checking bench for fifo_sync_param
module tb_fifo_sync_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       flush_a, vin_a, rout_a, irdy_a, vout_a, af_a, ae_a;
    logic [7:0] din_a, dout_a;
    logic [4:0] lvl_a;

    logic       flush_b, vin_b, rout_b, irdy_b, vout_b, af_b, ae_b;
    logic [7:0] din_b, dout_b;
    logic [2:0] lvl_b;

    fifo_sync_param #(.DATA_W(8), .DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush_a),
        .data_in(din_a), .data_in_vld(vin_a), .data_in_rdy(irdy_a),
        .data_out(dout_a), .data_out_vld(vout_a), .data_out_rdy(rout_a),
        .level(lvl_a), .almost_full(af_a), .almost_empty(ae_a)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(5)) u_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .data_in(din_b), .data_in_vld(vin_b), .data_in_rdy(irdy_b),
        .data_out(dout_b), .data_out_vld(vout_b), .data_out_rdy(rout_b),
        .level(lvl_b), .almost_full(af_b), .almost_empty(ae_b)
    );

    // Reference model: plain queues of stored words.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] head_a();
        return (qa.size() > 0) ? qa[0] : 8'h00;
    endfunction

    function automatic logic [7:0] head_b();
        return (qb.size() > 0) ? qb[0] : 8'h00;
    endfunction

    // Advance one clock edge, applying the queue rules to the model.
    task automatic tick();
        bit         push_a, pop_a, push_b, pop_b;
        logic [7:0] da, db;
        push_a = rst && !flush_a && vin_a && (qa.size() < 16);
        pop_a  = (qa.size() > 0) && rout_a;
        push_b = rst && !flush_b && vin_b && (qb.size() < 5);
        pop_b  = (qb.size() > 0) && rout_b;
        da = din_a;
        db = din_b;
        @(posedge clk);
        #1;
        if (!rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (flush_a) qa.delete();
            else begin
                if (pop_a)  void'(qa.pop_front());
                if (push_a) qa.push_back(da);
            end
            if (flush_b) qb.delete();
            else begin
                if (pop_b)  void'(qb.pop_front());
                if (push_b) qb.push_back(db);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (lvl_a !== 5'd0)  begin bad++; $display("FAIL reset_level got=%0d exp=0", lvl_a); end
        total++; if (vout_a !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", vout_a); end
        total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout_a); end
        total++; if (irdy_a !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", irdy_a); end
        total++; if (af_a !== 1'b0)   begin bad++; $display("FAIL reset_af got=%b exp=0", af_a); end
        total++; if (ae_a !== 1'b1)   begin bad++; $display("FAIL reset_ae got=%b exp=1", ae_a); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (irdy_a !== 1'b1) begin bad++; $display("FAIL release_rdy got=%b exp=1", irdy_a); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            vin_a = 1'b1;
            din_a = 8'(i);
            tick();
            total++; if (int'(lvl_a) !== qa.size()) begin bad++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, lvl_a, qa.size()); end
            total++; if (af_a !== (qa.size() >= 14)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, af_a, qa.size() >= 14); end
            total++; if (irdy_a !== (qa.size() < 16)) begin bad++; $display("FAIL fill_rdy i=%0d got=%b exp=%b", i, irdy_a, qa.size() < 16); end
            total++; if (dout_a !== 8'h01) begin bad++; $display("FAIL fill_head i=%0d got=%h exp=01", i, dout_a); end
        end
        vin_a = 1'b0;
        total++; if (lvl_a !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", lvl_a); end
    endtask

    task automatic test_drain();
        rout_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (vout_a !== 1'b1) begin bad++; $display("FAIL drain_vld i=%0d got=%b exp=1", i, vout_a); end
            total++; if (dout_a !== 8'(i + 1)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, dout_a, 8'(i + 1)); end
            tick();
            total++; if (int'(lvl_a) !== qa.size()) begin bad++; $display("FAIL drain_level i=%0d got=%0d exp=%0d", i, lvl_a, qa.size()); end
            total++; if (ae_a !== (qa.size() <= 2)) begin bad++; $display("FAIL drain_ae i=%0d got=%b exp=%b", i, ae_a, qa.size() <= 2); end
            if (i == 0) begin
                total++; if (irdy_a !== 1'b1) begin bad++; $display("FAIL unfull_rdy got=%b exp=1", irdy_a); end
            end
        end
        rout_a = 1'b0;
        total++; if (vout_a !== 1'b0) begin bad++; $display("FAIL empty_vld got=%b exp=0", vout_a); end
        total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL empty_dout got=%h exp=00", dout_a); end
    endtask

    task automatic test_steady();
        vin_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din_a = 8'($urandom);
            tick();
        end
        rout_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din_a = 8'($urandom);
            total++; if (dout_a !== head_a()) begin bad++; $display("FAIL steady_data i=%0d got=%h exp=%h", i, dout_a, head_a()); end
            tick();
            total++; if (lvl_a !== 5'd5) begin bad++; $display("FAIL steady_level i=%0d got=%0d exp=5", i, lvl_a); end
        end
        vin_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (dout_a !== head_a()) begin bad++; $display("FAIL steady_drain i=%0d got=%h exp=%h", i, dout_a, head_a()); end
            tick();
        end
        rout_a = 1'b0;
        total++; if (vout_a !== 1'b0) begin bad++; $display("FAIL steady_empty got=%b exp=0", vout_a); end
    endtask

    task automatic test_flush();
        vin_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din_a = 8'($urandom);
            tick();
        end
        total++; if (lvl_a !== 5'd9) begin bad++; $display("FAIL preflush_level got=%0d exp=9", lvl_a); end
        flush_a = 1'b1;
        rout_a  = 1'b1;
        din_a   = 8'hAA;
        #1;
        total++; if (irdy_a !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%b exp=0", irdy_a); end
        tick();
        flush_a = 1'b0;
        vin_a   = 1'b0;
        rout_a  = 1'b0;
        #1;
        total++; if (lvl_a !== 5'd0)   begin bad++; $display("FAIL flush_level got=%0d exp=0", lvl_a); end
        total++; if (vout_a !== 1'b0)  begin bad++; $display("FAIL flush_vld got=%b exp=0", vout_a); end
        total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL flush_dout got=%h exp=00", dout_a); end
        total++; if (ae_a !== 1'b1)    begin bad++; $display("FAIL flush_ae got=%b exp=1", ae_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            vin_a   = 1'($urandom);
            rout_a  = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
            flush_a = ($urandom_range(0, 39) == 0);
            din_a   = 8'($urandom);
            #1;
            total++; if (int'(lvl_a) !== qa.size()) begin bad++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, lvl_a, qa.size()); end
            total++; if (dout_a !== head_a()) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, dout_a, head_a()); end
            total++; if (vout_a !== (qa.size() != 0)) begin bad++; $display("FAIL rnd_vld i=%0d got=%b exp=%b", i, vout_a, qa.size() != 0); end
            total++; if (irdy_a !== (!flush_a && qa.size() < 16)) begin bad++; $display("FAIL rnd_rdy i=%0d got=%b exp=%b", i, irdy_a, !flush_a && qa.size() < 16); end
            total++; if (af_a !== (qa.size() >= 14)) begin bad++; $display("FAIL rnd_af i=%0d got=%b exp=%b", i, af_a, qa.size() >= 14); end
            total++; if (ae_a !== (qa.size() <= 2)) begin bad++; $display("FAIL rnd_ae i=%0d got=%b exp=%b", i, ae_a, qa.size() <= 2); end
            tick();
        end
        vin_a   = 1'b0;
        rout_a  = 1'b0;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
    endtask

    task automatic test_wrap_small();
        int idx  = 0;
        int pops = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            vin_b  = (idx < 7);
            din_b  = 8'(8'h30 + idx);
            rout_b = cyc[0];
            #1;
            total++; if (irdy_b !== (qb.size() < 5)) begin bad++; $display("FAIL wrap_rdy c=%0d got=%b exp=%b", cyc, irdy_b, qb.size() < 5); end
            total++; if (int'(lvl_b) !== qb.size()) begin bad++; $display("FAIL wrap_level c=%0d got=%0d exp=%0d", cyc, lvl_b, qb.size()); end
            total++; if (af_b !== (qb.size() >= 3)) begin bad++; $display("FAIL wrap_af c=%0d got=%b exp=%b", cyc, af_b, qb.size() >= 3); end
            total++; if (dout_b !== head_b()) begin bad++; $display("FAIL wrap_model c=%0d got=%h exp=%h", cyc, dout_b, head_b()); end
            if (vout_b && rout_b) begin
                total++; if (dout_b !== 8'(8'h30 + pops)) begin bad++; $display("FAIL wrap_order c=%0d got=%h exp=%h", cyc, dout_b, 8'(8'h30 + pops)); end
                pops++;
            end
            if (vin_b && qb.size() < 5) idx++;
            tick();
        end
        vin_b  = 1'b0;
        rout_b = 1'b0;
        total++; if (pops !== 7) begin bad++; $display("FAIL wrap_count got=%0d exp=7", pops); end
        total++; if (vout_b !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", vout_b); end
    endtask

    task automatic test_async_reset();
        vin_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din_a = 8'($urandom);
            tick();
        end
        vin_a = 1'b0;
        total++; if (lvl_a !== 5'd7) begin bad++; $display("FAIL prerst_level got=%0d exp=7", lvl_a); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        total++; if (lvl_a !== 5'd0)   begin bad++; $display("FAIL arst_level got=%0d exp=0", lvl_a); end
        total++; if (vout_a !== 1'b0)  begin bad++; $display("FAIL arst_vld got=%b exp=0", vout_a); end
        total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h exp=00", dout_a); end
        total++; if (irdy_a !== 1'b0)  begin bad++; $display("FAIL arst_rdy got=%b exp=0", irdy_a); end
        total++; if (ae_a !== 1'b1)    begin bad++; $display("FAIL arst_ae got=%b exp=1", ae_a); end
        total++; if (af_a !== 1'b0)    begin bad++; $display("FAIL arst_af got=%b exp=0", af_a); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (irdy_a !== 1'b1) begin bad++; $display("FAIL arst_release_rdy got=%b exp=1", irdy_a); end
        vin_a = 1'b1;
        din_a = 8'h5A;
        tick();
        din_a = 8'h6B;
        tick();
        vin_a = 1'b0;
        total++; if (dout_a !== 8'h5A) begin bad++; $display("FAIL arst_first got=%h exp=5a", dout_a); end
        rout_a = 1'b1;
        tick();
        total++; if (dout_a !== 8'h6B) begin bad++; $display("FAIL arst_second got=%h exp=6b", dout_a); end
        tick();
        rout_a = 1'b0;
        total++; if (vout_a !== 1'b0) begin bad++; $display("FAIL arst_empty got=%b exp=0", vout_a); end
    endtask

    initial begin
        rst     = 1'b0;
        flush_a = 1'b0; vin_a = 1'b0; rout_a = 1'b0; din_a = 8'h00;
        flush_b = 1'b0; vin_b = 1'b0; rout_b = 1'b0; din_b = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_flush();
        test_random();
        test_wrap_small();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 16: storage entries, legal range 2..1024, power of two not required.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when level >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when level <= AE_LEVEL.
REQ-005 Localparam LVL_W = $clog2(DEPTH+1): width of the level output.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 flush  input  1  synchronous clear of all stored entries.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 data_in_vld  input  1  write request.
REQ-011 data_in_rdy  output  1  FIFO can accept a word.
REQ-012 data_out  output  DATA_W  head-of-queue data.
REQ-013 data_out_vld  output  1  data_out holds a valid word.
REQ-014 data_out_rdy  input  1  consumer accepts data_out.
REQ-015 level  output  LVL_W  current number of stored entries.
REQ-016 almost_full  output  1  level >= AF_LEVEL.
REQ-017 almost_empty  output  1  level <= AE_LEVEL.

Function
REQ-018 Push occurs on a rising edge when data_in_vld && data_in_rdy; pop occurs when data_out_vld && data_out_rdy.
REQ-019 data_in_rdy = rst && !flush && (level < DEPTH); it does not depend on data_out_rdy, so there is no write-through when full.
REQ-020 data_out_vld = (level != 0); data_out = entry at the read pointer when valid, else all zeros.
REQ-021 First-word latency: a word pushed on edge N is presented with data_out_vld=1 from edge N to edge N+1 onward; there is no same-cycle bypass when empty.
REQ-022 Ordering is strictly FIFO; data is never lost, duplicated or reordered.
REQ-023 Write and read pointers range over 0..DEPTH-1 and wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-024 Level update per edge: push only +1, pop only -1, push and pop together unchanged (legal at any level 1..DEPTH-1), neither unchanged.
REQ-025 Full state (level == DEPTH): data_in_rdy=0 and a pop frees one slot, so data_in_rdy=1 on the following cycle.
REQ-026 Empty state (level == 0): data_out_vld=0 and data_out_rdy is ignored.
REQ-027 flush=1 at an edge sets both pointers to 0 and level to 0, overriding any push or pop in that cycle.
REQ-028 almost_full, almost_empty and level are registered-state derived and reflect the level after the last edge.
REQ-029 Storage array contents are not reset; only pointers, level and flags are reset.

Reset
REQ-030 While rst=0: level=0, data_out_vld=0, data_out=0, data_in_rdy=0, almost_full=0 (when AF_LEVEL>0), almost_empty=1, pointers=0.
REQ-031 Reset asserted mid-operation discards all contents immediately without waiting for clk.
REQ-032 data_in_rdy rises combinationally on rst deassertion; the first push is accepted on the first rising edge after release.

Verification
REQ-033 Reset release with DEPTH=16: push 0x01..0x10 back-to-back -> level 16, almost_full asserted from level 14, data_in_rdy=0 after the 16th push.
REQ-034 Drain a full FIFO with data_out_rdy=1 -> data_out 0x01..0x10 in order, level 0, almost_empty=1 from level 2, data_out_vld=0 after the last pop.
REQ-035 At level 5, hold push and pop for 40 cycles -> level remains 5, output order matches input across pointer wrap.
REQ-036 DEPTH=5: push 7 words while popping at half rate -> pointers wrap correctly at 4->0 and no word is lost or repeated.
REQ-037 At level 9, assert flush together with push and pop -> level 0 next cycle, pushed word discarded, data_out_vld=0.
REQ-038 At level 7, assert rst=0 between clock edges -> outputs take reset values immediately; after release, the first pushed word is the first word popped.
